fb_pair_reader: RTL

FB_PAIR_READER -- requirements
Module: fb_pair_reader

---
 rtl/fb_pair_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fb_pair_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fb_pair_reader
//  Purpose  : Reads NUM_PAIRS word pairs from a dual-port memory starting at
//             BASE_PAIR and streams them as A,B words over a ready/valid port.
//  Revision : 1.0 - initial release
// ============================================================================
module fb_pair_reader #(
  parameter int BASE_PAIR = 7168,
  parameter int NUM_PAIRS = 128,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [13:0]       addr_a,
  output logic [13:0]       addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [12:0] c_base_pair  = 13'(BASE_PAIR);
  localparam logic [12:0] c_last_issue = 13'(NUM_PAIRS - 1);
  localparam logic [13:0] c_last_word  = 14'(2 * NUM_PAIRS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [12:0]       r_pair;
  logic [12:0]       r_issued;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_count;
  logic [13:0]       r_word_cnt;

  logic [3:0]        w_fill;
  logic              w_pop;
  logic              w_last_beat;
  logic              w_start_ok;

  // Buffered words plus the two words still coming back from memory.
  assign w_fill      = {1'b0, r_count} + (r_inflight ? 4'd2 : 4'd0);
  assign w_pop       = out_valid && out_ready;
  assign w_last_beat = w_pop && out_last;
  assign w_start_ok  = (r_state == ST_IDLE) && start;

  assign addr_a    = {r_pair, 1'b0};
  assign addr_b    = {r_pair, 1'b1};
  assign out_valid = (r_count != 3'd0);
  assign out_data  = out_valid ? r_fifo[r_rd_ptr] : '0;
  assign out_last  = out_valid && (r_word_cnt == c_last_word);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    rd_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (!reset && (w_fill <= 4'd2)) begin
          rd_en = 1'b1;
          if (r_issued == c_last_issue) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pair     <= c_base_pair;
      r_issued   <= 13'd0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_word_cnt <= 14'd0;
    end else begin
      r_inflight <= rd_en;
      if (w_start_ok) begin
        r_pair   <= c_base_pair;
        r_issued <= 13'd0;
      end else if (rd_en) begin
        r_pair   <= r_pair + 13'd1;
        r_issued <= r_issued + 13'd1;
      end
      if (w_start_ok) begin
        r_word_cnt <= 14'd0;
      end else if (w_pop) begin
        r_word_cnt <= r_word_cnt + 14'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_wr_ptr <= r_wr_ptr + (r_inflight ? 2'd2 : 2'd0);
      r_count  <= r_count + (r_inflight ? 3'd2 : 3'd0) - (w_pop ? 3'd1 : 3'd0);
    end
  end

  // Data storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo[r_wr_ptr]        <= rd_data_a;
      r_fifo[r_wr_ptr + 2'd1] <= rd_data_b;
    end
  end

endmodule
`default_nettype wire
